cmp_config_loader: RTL

//  Parses the comparator-configuration packet body (hash count + 32-bit compare words) from a byte stream
//  and writes it into the comparator's 8-bit-wide hash memory. Sits directly upstream of comparator.

---
 rtl/cmp_config_loader.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/cmp_config_loader.sv
// Byte-stream loader for the comparator hash list: count, 4*N data bytes, [checksum], 8'hCC terminator.
// Optional checksum byte enabled by defining CMP_CONFIG_CHECKSUM_EN.
module cmp_config_loader #(
    parameter int unsigned HASH_NUM_MSB   = 3,
    parameter int unsigned HASH_COUNT_MSB = 4,
    parameter int unsigned NUM_HASHES     = 16
) (
    input  logic                      CLK,
    input  logic                      rst,
    input  logic [7:0]                in_din,
    input  logic                      in_valid,
    output logic                      in_rd_en,
    input  logic                      cmp_busy,
    output logic [7:0]                dout,
    output logic                      wr_en,
    output logic [HASH_NUM_MSB+2:0]   wr_addr,
    output logic [HASH_COUNT_MSB:0]   hash_count,
    output logic                      config_valid,
    output logic                      config_done,
    output logic                      err
);

    localparam int unsigned AW = HASH_NUM_MSB + 3;
    localparam int unsigned CW = HASH_NUM_MSB + 4;
    localparam int unsigned HW = HASH_COUNT_MSB + 1;
    localparam logic [7:0]  TERM_BYTE = 8'hCC;

    typedef enum logic [2:0] {
        CNT_LO = 3'd0,
        CNT_HI = 3'd1,
        DATA   = 3'd2,
        CKSUM  = 3'd3,
        TERM   = 3'd4,
        ERROR  = 3'd5
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      lo_q, lo_d;
    logic [HW-1:0]   pend_q, pend_d;
    logic [7:0]      dout_q, dout_d;
    logic            wr_en_q, wr_en_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [HW-1:0]   hc_q, hc_d;
    logic            valid_q, valid_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
`ifdef CMP_CONFIG_CHECKSUM_EN
    logic [7:0]      xor_q, xor_d;
`endif

    logic            rd_en_c;
    logic            acc_c;
    logic [15:0]     n_c;
    logic [CW-1:0]   total_c;
    logic [CW-1:0]   cnt_inc_c;

    // Read-enable is combinational so a busy comparator stalls DATA within the same cycle.
    assign rd_en_c   = (state_q == DATA) ? ~cmp_busy
                     : (state_q == CNT_LO || state_q == CNT_HI ||
                        state_q == CKSUM  || state_q == TERM);
    assign in_rd_en  = rd_en_c & ~rst;
    assign acc_c     = in_valid & in_rd_en;
    assign n_c       = {in_din, lo_q};
    assign total_c   = CW'({pend_q, 2'b00});
    assign cnt_inc_c = cnt_q + CW'(1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lo_d      = lo_q;
        pend_d    = pend_q;
        dout_d    = dout_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        hc_d      = hc_q;
        valid_d   = valid_q;
        done_d    = 1'b0;
        err_d     = err_q;
`ifdef CMP_CONFIG_CHECKSUM_EN
        xor_d     = xor_q;
`endif
        case (state_q)
            CNT_LO: if (acc_c) begin
                lo_d    = in_din;
                valid_d = 1'b0;
`ifdef CMP_CONFIG_CHECKSUM_EN
                xor_d   = in_din;
`endif
                state_d = CNT_HI;
            end
            CNT_HI: if (acc_c) begin
                if (n_c == 16'd0 || n_c > 16'(NUM_HASHES)) begin
                    state_d = ERROR;
                end else begin
                    pend_d  = HW'(n_c);
                    cnt_d   = '0;
`ifdef CMP_CONFIG_CHECKSUM_EN
                    xor_d   = xor_q ^ in_din;
`endif
                    state_d = DATA;
                end
            end
            DATA: if (acc_c) begin
                dout_d    = in_din;
                wr_en_d   = 1'b1;
                wr_addr_d = AW'(cnt_q);
                cnt_d     = cnt_inc_c;
`ifdef CMP_CONFIG_CHECKSUM_EN
                xor_d     = xor_q ^ in_din;
                if (cnt_inc_c == total_c) state_d = CKSUM;
`else
                if (cnt_inc_c == total_c) state_d = TERM;
`endif
            end
`ifdef CMP_CONFIG_CHECKSUM_EN
            CKSUM: if (acc_c) begin
                state_d = (in_din == xor_q) ? TERM : ERROR;
            end
`endif
            TERM: if (acc_c) begin
                if (in_din == TERM_BYTE) begin
                    hc_d    = pend_q;
                    valid_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = CNT_LO;
                end else begin
                    state_d = ERROR;
                end
            end
            ERROR:   state_d = ERROR;
            default: state_d = ERROR;
        endcase
        // ERROR is terminal: error flag sticks and the list is no longer usable.
        if (state_d == ERROR) begin
            err_d   = 1'b1;
            valid_d = 1'b0;
            wr_en_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q   <= CNT_LO;
            cnt_q     <= '0;
            lo_q      <= '0;
            pend_q    <= '0;
            dout_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            hc_q      <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef CMP_CONFIG_CHECKSUM_EN
            xor_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lo_q      <= lo_d;
            pend_q    <= pend_d;
            dout_q    <= dout_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            hc_q      <= hc_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            err_q     <= err_d;
`ifdef CMP_CONFIG_CHECKSUM_EN
            xor_q     <= xor_d;
`endif
        end
    end

    assign dout         = dout_q;
    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign hash_count   = hc_q;
    assign config_valid = valid_q;
    assign config_done  = done_q;
    assign err          = err_q;

endmodule
